// File: rtl/peak_search.sv
// Scans sizeN 128-bit results in SRAM and reports the largest real part, its index,
// and whether it exceeds a latched threshold. Read-only on SRAM; one peak per run.
module peak_search #(
   parameter int unsigned sizeN = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        busy,
   output logic        ready,
   input  logic [17:0] sramStartAddr,
   input  logic [63:0] threshold,
   input  logic [15:0] sramDataRead,
   output logic [17:0] sramAddr,
   output logic        sramOutEnable,
   output logic        sramWriteEnable,
   output logic [7:0]  peakIndex,
   output logic [63:0] peakValue,
   output logic        detected,
   output logic [7:0]  debug
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StSetup   = 3'd1;
   localparam logic [2:0] StAddr    = 3'd2;
   localparam logic [2:0] StWait    = 3'd3;
   localparam logic [2:0] StCapture = 3'd4;
   localparam logic [2:0] StCompare = 3'd5;
   localparam logic [2:0] StDone    = 3'd6;

   localparam logic [7:0] LastIdx = 8'(sizeN - 1);

   logic [2:0]  state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [2:0]  word_q, word_d;
   logic [17:0] base_q, base_d;
   logic [63:0] thr_q, thr_d;
   logic [63:0] cand_q, cand_d;
   logic [63:0] best_q, best_d;
   logic [7:0]  best_idx_q, best_idx_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic [17:0] addr_q, addr_d;
   logic        oe_q, oe_d;
   logic [7:0]  peak_idx_q, peak_idx_d;
   logic [63:0] peak_val_q, peak_val_d;
   logic        det_q, det_d;

   // Element i occupies 8 words; the sum wraps naturally at 18 bits.
   function automatic logic [17:0] elem_addr(input logic [17:0] base, input logic [7:0] i,
                                             input logic [2:0] w);
      return base + {7'd0, i, 3'd0} + {15'd0, w};
   endfunction

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      base_d     = base_q;
      thr_d      = thr_q;
      cand_d     = cand_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      addr_d     = addr_q;
      oe_d       = oe_q;
      peak_idx_d = peak_idx_q;
      peak_val_d = peak_val_q;
      det_d      = det_q;
      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StSetup;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               base_d  = sramStartAddr;
               thr_d   = threshold;
            end
         end
         StSetup: begin
            idx_d   = 8'd0;
            word_d  = 3'd4;
            oe_d    = 1'b0;
            addr_d  = elem_addr(base_q, 8'd0, 3'd4);
            state_d = StAddr;
         end
         StAddr:  state_d = StWait;
         StWait:  state_d = StCapture;
         StCapture: begin
            cand_d = {sramDataRead, cand_q[63:16]};
            if (word_q == 3'd7) begin
               state_d = StCompare;
               if (idx_q == LastIdx) oe_d = 1'b1;
            end else begin
               word_d  = word_q + 3'd1;
               addr_d  = elem_addr(base_q, idx_q, word_q + 3'd1);
               state_d = StAddr;
            end
         end
         StCompare: begin
            // Strictly greater only, so the lowest index wins a tie.
            if ((idx_q == 8'd0) || (cand_q > best_q)) begin
               best_d     = cand_q;
               best_idx_d = idx_q;
            end
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 8'd1;
               word_d  = 3'd4;
               addr_d  = elem_addr(base_q, idx_q + 8'd1, 3'd4);
               state_d = StAddr;
            end
         end
         StDone: begin
            peak_val_d = best_q;
            peak_idx_d = best_idx_q;
            det_d      = best_q > thr_q;
            busy_d     = 1'b0;
            ready_d    = 1'b1;
            oe_d       = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= 8'd0;
         word_q     <= 3'd4;
         base_q     <= 18'd0;
         thr_q      <= 64'd0;
         cand_q     <= 64'd0;
         best_q     <= 64'd0;
         best_idx_q <= 8'd0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         addr_q     <= 18'd0;
         oe_q       <= 1'b1;
         peak_idx_q <= 8'd0;
         peak_val_q <= 64'd0;
         det_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         base_q     <= base_d;
         thr_q      <= thr_d;
         cand_q     <= cand_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         addr_q     <= addr_d;
         oe_q       <= oe_d;
         peak_idx_q <= peak_idx_d;
         peak_val_q <= peak_val_d;
         det_q      <= det_d;
      end
   end

   assign busy            = busy_q;
   assign ready           = ready_q;
   assign sramAddr        = addr_q;
   assign sramOutEnable   = oe_q;
   assign sramWriteEnable = 1'b1;
   assign peakIndex       = peak_idx_q;
   assign peakValue       = peak_val_q;
   assign detected        = det_q;
   assign debug           = {5'd0, state_q};

endmodule

// File: tb/tb_peak_search.sv
// Bench for peak_search: a 64-element and a 4-element instance over a shared SRAM model
// with two-cycle read latency, checked against a plain max-search reference.
module tb_peak_search;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [15:0] mem [0:262143];

   logic        en_a, busy_a, ready_a, oe_a, we_a, det_a;
   logic [17:0] start_a, addr_a;
   logic [63:0] thr_a, val_a;
   logic [15:0] rd_a, rd_a1;
   logic [7:0]  idx_a, dbg_a;

   logic        en_b, busy_b, ready_b, oe_b, we_b, det_b;
   logic [17:0] start_b, addr_b;
   logic [63:0] thr_b, val_b;
   logic [15:0] rd_b, rd_b1;
   logic [7:0]  idx_b, dbg_b;

   peak_search #(.sizeN(64)) dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .busy(busy_a), .ready(ready_a),
      .sramStartAddr(start_a), .threshold(thr_a), .sramDataRead(rd_a), .sramAddr(addr_a),
      .sramOutEnable(oe_a), .sramWriteEnable(we_a), .peakIndex(idx_a), .peakValue(val_a),
      .detected(det_a), .debug(dbg_a)
   );

   peak_search #(.sizeN(4)) dut_b (
      .clk(clk), .reset(reset), .enable(en_b), .busy(busy_b), .ready(ready_b),
      .sramStartAddr(start_b), .threshold(thr_b), .sramDataRead(rd_b), .sramAddr(addr_b),
      .sramOutEnable(oe_b), .sramWriteEnable(we_b), .peakIndex(idx_b), .peakValue(val_b),
      .detected(det_b), .debug(dbg_b)
   );

   // Data appears two clocks after the address is presented.
   always @(posedge clk) begin
      rd_a1 <= mem[addr_a];
      rd_a  <= rd_a1;
      rd_b1 <= mem[addr_b];
      rd_b  <= rd_b1;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int both_hi = 0;
   int we_low  = 0;
   int oe_idle = 0;
   int rise_a  = 0;
   logic ready_a_prev = 1'b0;
   logic [17:0] addr_log [$];

   always @(negedge clk) begin
      if ((busy_a && ready_a) || (busy_b && ready_b)) both_hi++;
      if (!we_a || !we_b) we_low++;
      if ((ready_a && !oe_a) || (ready_b && !oe_b)) oe_idle++;
      if (ready_a && !ready_a_prev) rise_a++;
      ready_a_prev = ready_a;
      if (dbg_b == 8'd2) addr_log.push_back(addr_b);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] vals [0:63];

   task automatic load_elem(input logic [17:0] base, input int i, input logic [63:0] v,
                            input logic [15:0] imag);
      logic [17:0] a;
      for (int w = 0; w < 8; w++) begin
         a = base + 18'(i * 8 + w);
         mem[a] = (w < 4) ? imag : v[16*(w-4) +: 16];
      end
   endtask

   task automatic load_all(input logic [17:0] base, input int n, input logic rnd_imag);
      for (int i = 0; i < n; i++)
         load_elem(base, i, vals[i], rnd_imag ? 16'($urandom) : 16'hFFFF);
   endtask

   // Reference: largest value, first occurrence on ties.
   task automatic ref_peak(input int n, output logic [7:0] bi, output logic [63:0] bv);
      bi = 8'd0;
      bv = vals[0];
      for (int i = 1; i < n; i++)
         if (vals[i] > bv) begin
            bv = vals[i];
            bi = 8'(i);
         end
   endtask

   // Runs one scan on the 64-element DUT. At poke_at cycles into the scan the inputs are
   // disturbed (enable pulse, new base and threshold) to show they are ignored.
   task automatic run_a(input string tag, input logic [17:0] base, input logic [63:0] thr,
                        input int poke_at);
      logic [7:0]  ei, oi;
      logic [63:0] ev, ov;
      logic        od;
      int cnt;
      oi = idx_a; ov = val_a; od = det_a;
      ref_peak(64, ei, ev);
      start_a = base; thr_a = thr; en_a = 1'b1;
      step();
      en_a = 1'b0;
      check_eq({tag, " busy after start"}, 64'(busy_a), 64'd1);
      check_eq({tag, " ready drops"}, 64'(ready_a), 64'd0);
      cnt = 0;
      while (!ready_a && cnt < 2000) begin
         step();
         cnt++;
         if (cnt == poke_at) begin
            en_a = 1'b1; start_a = 18'($urandom); thr_a = 64'd0;
         end else begin
            en_a = 1'b0;
         end
         if (cnt == 400) begin
            check_eq({tag, " old index held"}, 64'(idx_a), 64'(oi));
            check_eq({tag, " old value held"}, val_a, ov);
            check_eq({tag, " old detect held"}, 64'(det_a), 64'(od));
         end
      end
      en_a = 1'b0;
      check_eq({tag, " ready latency"}, 64'(cnt), 64'd834);
      check_eq({tag, " peakIndex"}, 64'(idx_a), 64'(ei));
      check_eq({tag, " peakValue"}, val_a, ev);
      check_eq({tag, " detected"}, 64'(det_a), 64'(ev > thr));
      check_eq({tag, " busy clear"}, 64'(busy_a), 64'd0);
   endtask

   logic [63:0] r;
   logic [7:0]  ti;
   logic [63:0] tv;
   int          rb;
   int          cnt;

   initial begin
      reset = 1'b1; en_a = 1'b0; en_b = 1'b0;
      start_a = '0; start_b = '0; thr_a = '0; thr_b = '0;
      step(); step();
      check_eq("reset busy", 64'(busy_a), 64'd0);
      check_eq("reset ready", 64'(ready_a), 64'd0);
      check_eq("reset sramAddr", 64'(addr_a), 64'd0);
      check_eq("reset oe", 64'(oe_a), 64'd1);
      check_eq("reset peakValue", val_a, 64'd0);
      check_eq("reset state", 64'(dbg_a), 64'd0);
      reset = 1'b0;
      step();

      // Ramp
      for (int i = 0; i < 64; i++) vals[i] = 64'(i);
      load_all(18'h100, 64, 1'b1);
      run_a("ramp", 18'h100, 64'd10, 0);

      // Tie at 1.0, threshold equal to the peak
      for (int i = 0; i < 64; i++) vals[i] = 64'd0;
      vals[5] = 64'h3FF0000000000000;
      vals[40] = 64'h3FF0000000000000;
      load_all(18'h800, 64, 1'b1);
      run_a("tie", 18'h800, 64'h3FF0000000000000, 0);

      // Address wrap on the small instance
      vals[0] = 64'd1; vals[1] = 64'd9; vals[2] = 64'd3; vals[3] = 64'd2;
      load_all(18'h3FFF8, 4, 1'b1);
      addr_log.delete();
      start_b = 18'h3FFF8; thr_b = 64'd5; en_b = 1'b1;
      step();
      en_b = 1'b0;
      cnt = 0;
      while (!ready_b && cnt < 200) begin
         step();
         cnt++;
      end
      check_eq("wrap latency", 64'(cnt), 64'(13 * 4 + 2));
      check_eq("wrap peakIndex", 64'(idx_b), 64'd1);
      check_eq("wrap peakValue", val_b, 64'd9);
      check_eq("wrap detected", 64'(det_b), 64'd1);
      check_eq("wrap addr count", 64'(addr_log.size()), 64'd16);
      if (addr_log.size() == 16) begin
         check_eq("wrap addr e0w4", 64'(addr_log[0]), 64'h3FFFC);
         check_eq("wrap addr e0w7", 64'(addr_log[3]), 64'h3FFFF);
         check_eq("wrap addr e1w4", 64'(addr_log[4]), 64'h00004);
         check_eq("wrap addr e1w7", 64'(addr_log[7]), 64'h00007);
      end

      // Mid-scan enable and input changes are ignored; exactly one ready rise
      for (int i = 0; i < 64; i++) vals[i] = 64'($urandom_range(0, 1000));
      load_all(18'h1000, 64, 1'b1);
      rb = rise_a;
      run_a("handshake", 18'h1000, 64'd500, 100);
      repeat (5) step();
      check_eq("handshake single ready", 64'(rise_a - rb), 64'd1);
      check_eq("handshake ready held", 64'(ready_a), 64'd1);

      // Reset 300 cycles into a scan
      start_a = 18'h2000; thr_a = 64'd0; en_a = 1'b1;
      step();
      en_a = 1'b0;
      repeat (299) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("abort busy", 64'(busy_a), 64'd0);
      check_eq("abort ready", 64'(ready_a), 64'd0);
      check_eq("abort peakIndex", 64'(idx_a), 64'd0);
      check_eq("abort peakValue", val_a, 64'd0);
      check_eq("abort detected", 64'(det_a), 64'd0);
      check_eq("abort sramAddr", 64'(addr_a), 64'd0);
      check_eq("abort oe", 64'(oe_a), 64'd1);
      step();
      for (int i = 0; i < 64; i++) vals[i] = 64'($urandom_range(0, 1 << 20));
      load_all(18'h2000, 64, 1'b1);
      run_a("after abort", 18'h2000, 64'd1 << 19, 0);

      // Imaginary words all ones must not leak into the compare
      for (int i = 0; i < 64; i++) vals[i] = 64'd0;
      vals[17] = 64'd7;
      load_all(18'h3000, 64, 1'b0);
      run_a("imag", 18'h3000, 64'd6, 0);

      // Random scans with random bases (may wrap) and thresholds around the peak
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 64; i++) begin
            r = {$urandom, $urandom};
            vals[i] = (k % 2 == 0) ? {1'b0, r[62:0]} : 64'($urandom_range(0, 7));
         end
         ref_peak(64, ti, tv);
         rb = int'($urandom_range(0, 262143));
         load_all(18'(rb), 64, 1'b1);
         run_a($sformatf("rand%0d", k), 18'(rb), (k < 2) ? tv - 64'(k) : tv, 0);
      end

      check_eq("busy and ready never together", 64'(both_hi), 64'd0);
      check_eq("write enable never low", 64'(we_low), 64'd0);
      check_eq("oe high while ready", 64'(oe_idle), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/peak_search.md
# peak_search

Scans the modulus-square result vector left in SRAM by the matrix multiplier and finds the largest element, its index, and whether it exceeds a programmable threshold. It sits directly downstream of the multiplier. It is started after the multiplier's `ready` rises and reads the same SRAM port through the top-level mux. It is read-only on SRAM and reports one peak per run.

## Interface
Parameters:
- sizeN, 64: number of result elements; must be 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start request; sampled only in IDLE.
- busy  out  1  high while a scan is in progress.
- ready  out  1  high from scan completion until the next accepted enable.
- sramStartAddr  in  18  word address of element 0; each element occupies 8 consecutive 16-bit words.
- threshold  in  64  detection threshold, unsigned compare.
- sramDataRead  in  16  SRAM read data.
- sramAddr  out  18  SRAM word address.
- sramOutEnable  out  1  SRAM output enable, active-low.
- sramWriteEnable  out  1  SRAM write enable, active-low; held at 1 permanently.
- peakIndex  out  8  index of the largest element.
- peakValue  out  64  bits [127:64] (real part) of the largest element.
- detected  out  1  peakValue > threshold.
- debug  out  8  current state encoding.

## Operation
- Element layout: word k at element base holds bits [16k+15:16k] of the 128-bit result. Only words 4..7 (real-part double, non-negative) are read.
- Magnitude compare is a 64-bit unsigned integer compare. This is valid for non-negative IEEE doubles. NaN/negative values are not handled.
- On acceptance, sramStartAddr and threshold are latched. Changes to either during a scan have no effect.
- Address for element i, word w (4..7): latched base + i*8 + w, computed modulo 2^18 (wrap-around, no error).
- Word assembly: cand <= {sramDataRead, cand[63:16]} for w = 4,5,6,7 in order.
- Compare rules:
  - Element 0 always loads best value/index.
  - Later elements replace the current best only when strictly greater, so on ties the lowest index wins.
- States:
  - IDLE: enable=1 → SETUP, busy<=1, ready<=0.
  - SETUP: i<=0, w<=4, sramOutEnable<=0 → ADDR.
  - ADDR: drive sramAddr → WAIT.
  - WAIT: one wait state → CAPTURE.
  - CAPTURE: shift in sramDataRead.
    - If w==7 → COMPARE.
    - Else w<=w+1 → ADDR.
  - COMPARE: update best.
    - If i==sizeN-1 → DONE.
    - Else i<=i+1, w<=4 → ADDR.
  - DONE:
    - Copy best to peakValue/peakIndex.
    - detected <= best > threshold.
    - busy<=0, ready<=1, sramOutEnable<=1 → IDLE.
- Outputs peakIndex/peakValue/detected hold the previous result throughout a scan and change only in DONE.
- enable while busy is ignored. enable held high in IDLE with ready=1 starts a new scan immediately.
- Reset values:
  - 0: busy, ready, peakIndex, peakValue, detected, sramAddr.
  - 1: sramOutEnable, sramWriteEnable.
  - State returns to IDLE.
- Reset mid-scan aborts the scan with no partial result published.

## Timing
- SRAM read latency: data is valid in the CAPTURE cycle, i.e. 2 clocks after sramAddr is driven in ADDR.
- Per word: 3 cycles. Per element: 4×3 + 1 = 13 cycles.
- Enable sampled at edge T:
  - busy=1 from T+1.
  - ready=1 and results valid from T + 13*sizeN + 2. For sizeN=64 this is T+834.
- busy and ready are never simultaneously 1.
- sramOutEnable is low from the cycle after SETUP through the final CAPTURE. It is high in IDLE, SETUP-entry and DONE.

## Test plan
- Ramp: element i real part = i, sramStartAddr=0x100, threshold=10 → peakIndex=63, peakValue=63, detected=1, ready at T+834.
- Tie and threshold: all zero except elements 5 and 40 = 0x3FF0000000000000, threshold=0x3FF0000000000000 → peakIndex=5, detected=0 (strict compare).
- Address wrap: sramStartAddr=0x3FFF8, sizeN=4.
  - Element 0 is read at 0x3FFFC..0x3FFFF.
  - Element 1 is read at 0x00004..0x00007.
  - Values 1,9,3,2 → peakIndex=1.
- Busy/ready handshake: pulse enable again mid-scan → ignored, single ready. Then enable in IDLE → ready drops next cycle while old result is held until the new DONE.
- Reset mid-scan at cycle 300 → all outputs at reset values next cycle. A subsequent full scan returns the correct peak.
- Imag-part isolation: words 0..3 of every element = 0xFFFF, real parts all 0 except element 17 = 7 → peakIndex=17, peakValue=7; sramWriteEnable never 0.
